// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with stall-deferred redirects and misaligned-target trap
module pc_sequencer #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int IALIGN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            stall_i,
    input  logic            instr_valid_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic            cond_jump_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            trap_ack_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_step_o,
    output logic            fetch_valid_o,
    output logic            redirect_o,
    output logic            misalign_trap_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [1:0]      state_o,
    output logic [31:0]     advance_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, TRAP} state_t;
    state_t state, state_d;
    logic [XLEN-1:0] pc_d, pend, pend_d, trap_pc_d, eff_target;
    logic [31:0] cnt_d;
    logic redirect_d, trap_d, taken, misaligned;
    assign taken = instr_valid_i & (is_jal_i | is_jalr_i | (is_branch_i & cond_jump_i));
    assign eff_target = is_jalr_i ? {target_i[XLEN-1:1], 1'b0} : target_i;
    assign misaligned = |(eff_target & XLEN'(IALIGN - 1));
    assign pc_plus_step_o = pc_o + XLEN'(IALIGN);
    assign fetch_valid_o = (state == RUN) || (state == HOLD);
    assign state_o = state;
    always_comb begin
        state_d = state;
        pc_d = pc_o;
        pend_d = pend;
        trap_pc_d = trap_pc_o;
        cnt_d = advance_count_o;
        redirect_d = 1'b0;
        trap_d = 1'b0;
        case (state)
            IDLE: state_d = en_i ? RUN : IDLE;
            RUN: begin
                if (taken && misaligned) begin
                    pc_d = TRAP_VECTOR;
                    trap_pc_d = eff_target;
                    trap_d = 1'b1;
                    state_d = TRAP;
                end else if (stall_i) begin
                    pend_d = taken ? eff_target : pend;
                    state_d = taken ? HOLD : (en_i ? RUN : IDLE);
                end else begin
                    pc_d = taken ? eff_target : pc_plus_step_o;
                    redirect_d = taken;
                    cnt_d = advance_count_o + 32'd1;
                    state_d = en_i ? RUN : IDLE;
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    pc_d = pend;
                    redirect_d = 1'b1;
                    cnt_d = advance_count_o + 32'd1;
                    state_d = en_i ? RUN : IDLE;
                end
            end
            default: state_d = trap_ack_i ? RUN : TRAP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc_o <= RESET_VECTOR;
            pend <= '0;
            trap_pc_o <= '0;
            advance_count_o <= '0;
            redirect_o <= 1'b0;
            misalign_trap_o <= 1'b0;
        end else begin
            state <= state_d;
            pc_o <= pc_d;
            pend <= pend_d;
            trap_pc_o <= trap_pc_d;
            advance_count_o <= cnt_d;
            redirect_o <= redirect_d;
            misalign_trap_o <= trap_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven scoreboard bench for pc_sequencer (IALIGN=4 main, IALIGN=2 side instance)
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst, en, stall, valid, br, jal, jalr, cond, ack;
    logic [31:0] target;
    logic [31:0] pc, pcs, tpc, cnt, pc2, pcs2, tpc2, cnt2;
    logic fv, redir, trap, fv2, redir2, trap2;
    logic [1:0] st, st2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.IALIGN(4)) dut (
        .clk(clk), .rst(rst), .en_i(en), .stall_i(stall), .instr_valid_i(valid),
        .is_branch_i(br), .is_jal_i(jal), .is_jalr_i(jalr), .cond_jump_i(cond),
        .target_i(target), .trap_ack_i(ack), .pc_o(pc), .pc_plus_step_o(pcs),
        .fetch_valid_o(fv), .redirect_o(redir), .misalign_trap_o(trap),
        .trap_pc_o(tpc), .state_o(st), .advance_count_o(cnt)
    );

    pc_sequencer #(.IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .en_i(en), .stall_i(stall), .instr_valid_i(valid),
        .is_branch_i(br), .is_jal_i(jal), .is_jalr_i(jalr), .cond_jump_i(cond),
        .target_i(target), .trap_ack_i(ack), .pc_o(pc2), .pc_plus_step_o(pcs2),
        .fetch_valid_o(fv2), .redirect_o(redir2), .misalign_trap_o(trap2),
        .trap_pc_o(tpc2), .state_o(st2), .advance_count_o(cnt2)
    );

    // kind: 0 none, 1 branch taken, 2 branch not taken, 3 jal, 4 jalr
    typedef struct {
        logic rst, en, stall, v;
        int kind;
        logic [31:0] target;
        logic ack;
        logic [31:0] e_pc;
        logic [1:0] e_st;
        logic e_r, e_t;
        logic [31:0] e_cnt, e_tpc;
        logic c2;
        logic [31:0] e2_pc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic e, logic s, logic v, int k, logic [31:0] t, logic a,
                                logic [31:0] p, logic [1:0] sst, logic rr, logic tt,
                                logic [31:0] c, logic [31:0] tp, logic c2 = 0, logic [31:0] p2 = 0);
        vec_t x;
        x.rst = r; x.en = e; x.stall = s; x.v = v; x.kind = k; x.target = t; x.ack = a;
        x.e_pc = p; x.e_st = sst; x.e_r = rr; x.e_t = tt; x.e_cnt = c; x.e_tpc = tp;
        x.c2 = c2; x.e2_pc = p2;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t x);
        vec_t e;
        @(negedge clk);
        rst = x.rst; en = x.en; stall = x.stall; valid = x.v; target = x.target; ack = x.ack;
        br = (x.kind == 1) || (x.kind == 2);
        cond = (x.kind == 1);
        jal = (x.kind == 3);
        jalr = (x.kind == 4);
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc", pc, e.e_pc);
        chk("pc_plus_step", pcs, e.e_pc + 32'd4);
        chk("state", {30'd0, st}, {30'd0, e.e_st});
        chk("fetch_valid", {31'd0, fv}, {31'd0, (e.e_st == 2'd1) || (e.e_st == 2'd2)});
        chk("redirect", {31'd0, redir}, {31'd0, e.e_r});
        chk("misalign_trap", {31'd0, trap}, {31'd0, e.e_t});
        chk("count", cnt, e.e_cnt);
        chk("trap_pc", tpc, e.e_tpc);
        if (e.c2) chk("pc_ialign2", pc2, e.e2_pc);
    endtask

    initial begin
        rst = 1; en = 0; stall = 0; valid = 0; br = 0; jal = 0; jalr = 0; cond = 0; ack = 0; target = 0;
        //            rst en st v kind target        ack  pc            st r t cnt tpc
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  0));
        tbl.push_back(mk(1, 1, 0, 1, 3, 32'h40,       0, 32'h0,        0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h4,        1, 0, 0, 1,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h8,        1, 0, 0, 2,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'hc,        1, 0, 0, 3,  0));
        tbl.push_back(mk(0, 1, 0, 1, 3, 32'h20,       0, 32'h20,       1, 1, 0, 4,  0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'h80,       0, 32'h80,       1, 1, 0, 5,  0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h200,      0, 32'h84,       1, 0, 0, 6,  0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h200,      0, 32'h88,       1, 0, 0, 7,  0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,        0, 32'h88,       1, 0, 0, 7,  0));
        tbl.push_back(mk(0, 1, 1, 1, 3, 32'h40,       0, 32'h88,       2, 0, 0, 7,  0));
        tbl.push_back(mk(0, 1, 1, 1, 3, 32'h300,      0, 32'h88,       2, 0, 0, 7,  0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,        0, 32'h88,       2, 0, 0, 7,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h40,       1, 1, 0, 8,  0, 1, 32'h40));
        tbl.push_back(mk(0, 1, 0, 1, 4, 32'h103,      0, 32'h100,      3, 0, 1, 8,  32'h102, 1, 32'h102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h100,      3, 0, 0, 8,  32'h102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 8,  32'h102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h104,      0, 0, 0, 9,  32'h102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h104,      0, 0, 0, 9,  32'h102));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h104,      1, 0, 0, 9,  32'h102));
        tbl.push_back(mk(0, 1, 1, 1, 3, 32'h42,       0, 32'h100,      3, 0, 1, 9,  32'h42));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 9,  32'h42));
        tbl.push_back(mk(0, 1, 0, 1, 3, 32'hffff_fffc, 0, 32'hffff_fffc, 1, 1, 0, 10, 32'h42));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 11, 32'h42));
        tbl.push_back(mk(0, 1, 1, 1, 3, 32'h60,       0, 32'h0,        2, 0, 0, 11, 32'h42));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h60,       0, 1, 0, 12, 32'h42));
        foreach (tbl[i]) apply(tbl[i]);

        // reset in the middle of a deferred redirect discards the pending target
        apply(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h60, 1, 0, 0, 12, 32'h42));
        apply(mk(0, 1, 1, 1, 3, 32'h40, 0, 32'h60, 2, 0, 0, 12, 32'h42));
        apply(mk(1, 1, 1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0,  0));
        apply(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0,  0));
        apply(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h4,  1, 0, 0, 1,  0));

        // reset while trapped
        apply(mk(0, 1, 0, 1, 4, 32'h7,  0, 32'h100, 3, 0, 1, 1, 32'h6));
        apply(mk(1, 0, 0, 0, 0, 32'h0,  1, 32'h0,   0, 0, 0, 0, 0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
